// File: rtl/mem_mesh_pipe_pkg.sv
// Shared defaults and helpers for the pipelined per-core memory mesh.
package mem_mesh_pipe_pkg;

    localparam int DEF_CORES        = 8;
    localparam int DEF_LOG_CORES    = 3;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_MEM_DEPTH    = 32;
    localparam int DEF_SPREAD_WIDTH = 3;
    localparam int DEF_IO_PORTS     = 4;
    localparam int DEF_IO_FIRST     = 28;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Spread s covers every block whose index differs from the writer's only in
    // the low s-1 bits; this returns those s-1 "don't care" bits as a unary mask.
    function automatic int spread_to_unary(input int spread);
        int mask;
        mask = 0;
        for (int i = 0; i < 31; i++) begin
            if (i + 1 < spread) begin
                mask = mask | (1 << i);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_mesh_io_fifo.sv
// Output FIFO for one io port: valid/ready pop side, push side never stalls,
// sticky overflow when a push finds the FIFO full with no simultaneous pop.
module mem_mesh_io_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_buf [FIFO_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
    assign w_pop   = pop && !w_empty;
    assign w_push  = push && (!w_full || w_pop);
    assign w_drop  = push && w_full && !w_pop;

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage; contents are don't-care while empty since the output is masked.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= push_data;
        end
    end

    assign valid    = !w_empty;
    assign data     = w_empty ? '0 : r_buf[r_rd_ptr];
    assign overflow = r_overflow;

endmodule

// File: rtl/mem_mesh_pipe.sv
// Per-core memory mesh with one request stage, spread/priority resolution per
// cell, an io window at the top of the address space and per-port output FIFOs.
module mem_mesh_pipe
    import mem_mesh_pipe_pkg::*;
#(
    parameter int CORES        = DEF_CORES,
    parameter int LOG_CORES    = DEF_LOG_CORES,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
    parameter int SPREAD_WIDTH = DEF_SPREAD_WIDTH,
    parameter int IO_PORTS     = DEF_IO_PORTS,
    parameter int IO_FIRST     = DEF_IO_FIRST,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CORES-1:0]               we,
    input  logic [CORES*ADDR_WIDTH-1:0]    waddr,
    input  logic [CORES*SPREAD_WIDTH-1:0]  wspread,
    input  logic [CORES*DATA_WIDTH-1:0]    wdata,
    input  logic [CORES*ADDR_WIDTH-1:0]    raddr,
    output logic [CORES*DATA_WIDTH-1:0]    rdata,
    input  logic [IO_PORTS-1:0]            io_valid_in,
    input  logic [IO_PORTS*DATA_WIDTH-1:0] io_data_in,
    output logic [IO_PORTS-1:0]            io_valid_out,
    input  logic [IO_PORTS-1:0]            io_ready_out,
    output logic [IO_PORTS*DATA_WIDTH-1:0] io_data_out,
    output logic [IO_PORTS-1:0]            io_overflow
);

    // Stage S registers
    logic [CORES-1:0]               r_we;
    logic [CORES*ADDR_WIDTH-1:0]    r_waddr;
    logic [CORES*SPREAD_WIDTH-1:0]  r_wspread;
    logic [CORES*DATA_WIDTH-1:0]    r_wdata;
    logic [IO_PORTS-1:0]            r_io_valid;
    logic [IO_PORTS*DATA_WIDTH-1:0] r_io_data;

    // Unpacked views of the latched requests
    logic [ADDR_WIDTH-1:0]   w_addr      [CORES];
    logic [SPREAD_WIDTH-1:0] w_spread    [CORES];
    logic [DATA_WIDTH-1:0]   w_data      [CORES];
    logic [DATA_WIDTH-1:0]   w_io_data   [IO_PORTS];

    // w_tgt[c][b]: core c's latched write reaches block b; w_win: and it owns the cell
    logic [CORES-1:0]        w_tgt       [CORES];
    logic [CORES-1:0]        w_win       [CORES];
    logic [CORES-1:0]        w_io_hit;
    logic [IO_PORTS-1:0]     w_push;
    logic [DATA_WIDTH-1:0]   w_push_data [IO_PORTS];

    // Latch write and io requests; a reset discards anything pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= '0;
            r_waddr    <= '0;
            r_wspread  <= '0;
            r_wdata    <= '0;
            r_io_valid <= '0;
            r_io_data  <= '0;
        end else begin
            r_we       <= we;
            r_waddr    <= waddr;
            r_wspread  <= wspread;
            r_wdata    <= wdata;
            r_io_valid <= io_valid_in;
            r_io_data  <= io_data_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_unpack
            assign w_addr[gi]   = r_waddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_spread[gi] = r_wspread[gi*SPREAD_WIDTH +: SPREAD_WIDTH];
            assign w_data[gi]   = r_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (gi = 0; gi < IO_PORTS; gi++) begin : g_unpack_io
            assign w_io_data[gi] = r_io_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Spread each latched write to its set of target blocks.
    always_comb begin
        for (int c = 0; c < CORES; c++) begin
            w_tgt[c] = '0;
            if (r_we[c] && (w_spread[c] != '0) && (int'(w_addr[c]) < MEM_DEPTH)) begin
                for (int b = 0; b < CORES; b++) begin
                    if ((((b ^ c) & ~spread_to_unary(int'(w_spread[c]))) & (CORES - 1)) == 0) begin
                        w_tgt[c][b] = 1'b1;
                    end
                end
            end
        end
    end

    // Flag core writes that land on an io cell receiving io input this cycle.
    always_comb begin
        w_io_hit = '0;
        for (int c = 0; c < CORES; c++) begin
            for (int p = 0; p < IO_PORTS; p++) begin
                if (r_io_valid[p] && (int'(w_addr[c]) == IO_FIRST + p)) begin
                    w_io_hit[c] = 1'b1;
                end
            end
        end
    end

    // Per block and cell: higher spread beats lower, lower core index breaks ties.
    always_comb begin
        for (int c = 0; c < CORES; c++) begin
            w_win[c] = '0;
            for (int b = 0; b < CORES; b++) begin
                w_win[c][b] = w_tgt[c][b] && !w_io_hit[c];
                for (int d = 0; d < CORES; d++) begin
                    if ((d != c) && w_tgt[d][b] && (w_addr[d] == w_addr[c]) &&
                        ((w_spread[d] > w_spread[c]) ||
                         ((w_spread[d] == w_spread[c]) && (d < c)))) begin
                        w_win[c][b] = 1'b0;
                    end
                end
            end
        end
    end

    // A surviving full-mesh write to an io cell is forwarded to that port's FIFO.
    always_comb begin
        w_push = '0;
        for (int p = 0; p < IO_PORTS; p++) begin
            w_push_data[p] = '0;
        end
        for (int c = 0; c < CORES; c++) begin
            for (int p = 0; p < IO_PORTS; p++) begin
                if (w_win[c][0] && (int'(w_spread[c]) > LOG_CORES) &&
                    (int'(w_addr[c]) == IO_FIRST + p)) begin
                    w_push[p]      = 1'b1;
                    w_push_data[p] = w_data[c];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < CORES; gi++) begin : g_block
            logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
            logic [ADDR_WIDTH-1:0] w_raddr;
            logic [DATA_WIDTH-1:0] w_rd;

            // Commit winning core writes, then io input on its own cells.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int a = 0; a < MEM_DEPTH; a++) begin
                        r_mem[a] <= '0;
                    end
                end else begin
                    for (int c = 0; c < CORES; c++) begin
                        if (w_win[c][gi]) begin
                            r_mem[w_addr[c]] <= w_data[c];
                        end
                    end
                    for (int p = 0; p < IO_PORTS; p++) begin
                        if (r_io_valid[p]) begin
                            r_mem[ADDR_WIDTH'(IO_FIRST + p)] <= w_io_data[p];
                        end
                    end
                end
            end

            assign w_raddr = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Combinational read of the core's own block; out-of-range reads give 0.
            always_comb begin
                w_rd = '0;
                if (int'(w_raddr) < MEM_DEPTH) begin
                    w_rd = r_mem[w_raddr];
                end
            end

            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        end

        for (gi = 0; gi < IO_PORTS; gi++) begin : g_fifo
            mem_mesh_io_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .srst      (rst),
                .push      (w_push[gi]),
                .push_data (w_push_data[gi]),
                .pop       (io_ready_out[gi]),
                .valid     (io_valid_out[gi]),
                .data      (io_data_out[gi*DATA_WIDTH +: DATA_WIDTH]),
                .overflow  (io_overflow[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mem_mesh_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for mem_mesh_pipe: directed scenarios plus a randomized
// run compared against a cell-level reference model.
module tb_mem_mesh_pipe;

    localparam int CORES = 8;
    localparam int LOGC  = 3;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int SW    = 3;
    localparam int IOP   = 4;
    localparam int IOF   = 28;
    localparam int FD    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [CORES-1:0]    we;
    logic [CORES*AW-1:0] waddr;
    logic [CORES*SW-1:0] wspread;
    logic [CORES*DW-1:0] wdata;
    logic [CORES*AW-1:0] raddr;
    logic [CORES*DW-1:0] rdata;
    logic [IOP-1:0]      io_valid_in;
    logic [IOP*DW-1:0]   io_data_in;
    logic [IOP-1:0]      io_valid_out;
    logic [IOP-1:0]      io_ready_out;
    logic [IOP*DW-1:0]   io_data_out;
    logic [IOP-1:0]      io_overflow;

    int checks   = 0;
    int failures = 0;

    always #50 clk = ~clk;

    mem_mesh_pipe #(
        .CORES(CORES), .LOG_CORES(LOGC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MEM_DEPTH(DEPTH), .SPREAD_WIDTH(SW), .IO_PORTS(IOP), .IO_FIRST(IOF),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wspread(wspread),
        .wdata(wdata), .raddr(raddr), .rdata(rdata), .io_valid_in(io_valid_in),
        .io_data_in(io_data_in), .io_valid_out(io_valid_out),
        .io_ready_out(io_ready_out), .io_data_out(io_data_out),
        .io_overflow(io_overflow)
    );

    // ---------------- reference model ----------------
    int m_mem [CORES][DEPTH];
    int m_q   [IOP][$];
    bit m_ovf [IOP];
    bit                  p_live;
    logic [CORES-1:0]    p_we;
    logic [CORES*AW-1:0] p_waddr;
    logic [CORES*SW-1:0] p_wspread;
    logic [CORES*DW-1:0] p_wdata;
    logic [IOP-1:0]      p_iov;
    logic [IOP*DW-1:0]   p_iod;

    task automatic model_edge();
        bit popped [IOP];
        bit push   [IOP];
        int push_val [IOP];
        int best_sp  [CORES][DEPTH];
        int best_val [CORES][DEPTH];
        int s, a, dv;
        for (int p = 0; p < IOP; p++) begin
            popped[p]   = io_ready_out[p] && (m_q[p].size() > 0);
            push[p]     = 1'b0;
            push_val[p] = 0;
        end
        if (rst) begin
            for (int b = 0; b < CORES; b++)
                for (int x = 0; x < DEPTH; x++) m_mem[b][x] = 0;
            for (int p = 0; p < IOP; p++) begin
                m_q[p].delete();
                m_ovf[p] = 1'b0;
            end
            p_live = 1'b0;
            return;
        end
        if (p_live) begin
            for (int b = 0; b < CORES; b++)
                for (int x = 0; x < DEPTH; x++) best_sp[b][x] = -1;
            // Walk cores in ascending order; strict > keeps the lowest core on ties.
            for (int c = 0; c < CORES; c++) begin
                if (p_we[c]) begin
                    s  = int'(p_wspread[c*SW +: SW]);
                    a  = int'(p_waddr[c*AW +: AW]);
                    dv = int'(p_wdata[c*DW +: DW]);
                    if (s > 0 && a < DEPTH) begin
                        for (int b = 0; b < CORES; b++) begin
                            if (((b >> (s - 1)) == (c >> (s - 1))) && (s > best_sp[b][a])) begin
                                best_sp[b][a]  = s;
                                best_val[b][a] = dv;
                            end
                        end
                    end
                end
            end
            for (int p = 0; p < IOP; p++) begin
                if (best_sp[0][IOF + p] > LOGC && !p_iov[p]) begin
                    push[p]     = 1'b1;
                    push_val[p] = best_val[0][IOF + p];
                end
            end
            for (int b = 0; b < CORES; b++)
                for (int x = 0; x < DEPTH; x++)
                    if (best_sp[b][x] >= 0) m_mem[b][x] = best_val[b][x];
            for (int p = 0; p < IOP; p++)
                if (p_iov[p])
                    for (int b = 0; b < CORES; b++) m_mem[b][IOF + p] = int'(p_iod[p*DW +: DW]);
        end
        for (int p = 0; p < IOP; p++) begin
            if (popped[p]) void'(m_q[p].pop_front());
            if (push[p]) begin
                if (m_q[p].size() >= FD) m_ovf[p] = 1'b1;
                else m_q[p].push_back(push_val[p]);
            end
        end
        p_live    = 1'b1;
        p_we      = we;
        p_waddr   = waddr;
        p_wspread = wspread;
        p_wdata   = wdata;
        p_iov     = io_valid_in;
        p_iod     = io_data_in;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        we = '0; waddr = '0; wspread = '0; wdata = '0;
        io_valid_in = '0; io_data_in = '0;
    endtask

    task automatic set_write(input int c, input int a, input int s, input int d);
        we[c] = 1'b1;
        waddr[c*AW +: AW]   = AW'(a);
        wspread[c*SW +: SW] = SW'(s);
        wdata[c*DW +: DW]   = DW'(d);
        $display("txn write core=%0d addr=%0d spread=%0d data=0x%02h", c, a, s, d);
    endtask

    task automatic set_raddr(input int a);
        for (int c = 0; c < CORES; c++) raddr[c*AW +: AW] = AW'(a);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; clear_inputs(); io_ready_out = '0;
        tick(); tick();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(a);
            for (int c = 0; c < CORES; c++) begin
                checks++;
                if (rdata[c*DW +: DW] !== 8'h00) begin
                    failures++;
                    $display("FAIL reset_mem core=%0d addr=%0d got=%h exp=00", c, a, rdata[c*DW +: DW]);
                end
            end
        end
        checks++;
        if (io_valid_out !== 4'h0 || io_data_out !== '0 || io_overflow !== 4'h0) begin
            failures++;
            $display("FAIL reset_io valid=%b data=%h ovf=%b exp 0", io_valid_out, io_data_out, io_overflow);
        end
        $display("txn reset done");
    endtask

    task automatic test_spread();
        clear_inputs();
        set_write(3, 5, 2, 8'hA5);
        tick();
        clear_inputs();
        set_raddr(5);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== 8'h00) begin
                failures++;
                $display("FAIL spread_early core=%0d got=%h exp=00", c, rdata[c*DW +: DW]);
            end
        end
        tick();
        set_raddr(5);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== ((c == 2 || c == 3) ? 8'hA5 : 8'h00)) begin
                failures++;
                $display("FAIL spread_commit core=%0d got=%h exp=%h", c, rdata[c*DW +: DW],
                         (c == 2 || c == 3) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_conflict();
        logic [7:0] exp;
        clear_inputs();
        set_write(0, 7, 1, 8'h11);
        set_write(1, 7, 2, 8'h22);
        tick();
        clear_inputs();
        set_write(4, 7, 1, 8'h44);
        set_write(5, 7, 1, 8'h55);
        tick();
        clear_inputs();
        tick();
        set_raddr(7);
        for (int c = 0; c < CORES; c++) begin
            exp = (c < 2) ? 8'h22 : (c == 4) ? 8'h44 : (c == 5) ? 8'h55 : 8'h00;
            checks++;
            if (rdata[c*DW +: DW] !== exp) begin
                failures++;
                $display("FAIL conflict core=%0d got=%h exp=%h", c, rdata[c*DW +: DW], exp);
            end
        end
    endtask

    task automatic test_broadcast_fifo();
        logic [7:0] order [4];
        order[0] = 8'h3C; order[1] = 8'h01; order[2] = 8'h02; order[3] = 8'h03;
        io_ready_out = '0;
        clear_inputs();
        set_write(2, 28, 4, 8'h3C);
        tick();
        clear_inputs();
        tick();
        set_raddr(28);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== 8'h3C) begin
                failures++;
                $display("FAIL bcast_mem core=%0d got=%h exp=3c", c, rdata[c*DW +: DW]);
            end
        end
        checks++;
        if (io_valid_out[0] !== 1'b1 || io_data_out[7:0] !== 8'h3C) begin
            failures++;
            $display("FAIL bcast_fifo valid=%b data=%h exp valid=1 data=3c", io_valid_out[0], io_data_out[7:0]);
        end
        for (int k = 1; k <= 4; k++) begin
            clear_inputs();
            set_write(2, 28, 4, k);
            tick();
        end
        clear_inputs();
        tick();
        checks++;
        if (io_overflow !== 4'b0001) begin
            failures++;
            $display("FAIL bcast_overflow got=%b exp=0001", io_overflow);
        end
        set_raddr(28);
        checks++;
        if (rdata[0 +: DW] !== 8'h04) begin
            failures++;
            $display("FAIL bcast_dropped_mem got=%h exp=04", rdata[0 +: DW]);
        end
        io_ready_out[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (io_valid_out[0] !== 1'b1 || io_data_out[7:0] !== order[k]) begin
                failures++;
                $display("FAIL bcast_pop%0d valid=%b data=%h exp valid=1 data=%h", k, io_valid_out[0], io_data_out[7:0], order[k]);
            end
            tick();
        end
        io_ready_out[0] = 1'b0;
        checks++;
        if (io_valid_out[0] !== 1'b0 || io_data_out[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL bcast_drained valid=%b data=%h exp 0", io_valid_out[0], io_data_out[7:0]);
        end
    endtask

    task automatic test_io_override();
        clear_inputs();
        io_valid_in[1] = 1'b1;
        io_data_in[15:8] = 8'h77;
        $display("txn io_in port=1 data=0x77");
        set_write(0, 29, 4, 8'h99);
        tick();
        clear_inputs();
        tick();
        set_raddr(29);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== 8'h77) begin
                failures++;
                $display("FAIL io_override core=%0d got=%h exp=77", c, rdata[c*DW +: DW]);
            end
        end
        checks++;
        if (io_valid_out[1] !== 1'b0) begin
            failures++;
            $display("FAIL io_no_push valid=%b exp=0", io_valid_out[1]);
        end
    endtask

    task automatic test_full_push_pop();
        io_ready_out = '0;
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            set_write(5, 30, 4, 8'h10 + k);
            tick();
        end
        clear_inputs();
        io_ready_out[2] = 1'b1;
        tick();
        io_ready_out[2] = 1'b0;
        checks++;
        if (io_overflow[2] !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop_ovf got=%b exp=0", io_overflow[2]);
        end
        io_ready_out[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (io_valid_out[2] !== 1'b1 || io_data_out[23:16] !== 8'(8'h11 + k)) begin
                failures++;
                $display("FAIL full_pushpop_order%0d valid=%b data=%h exp=%h", k, io_valid_out[2], io_data_out[23:16], 8'(8'h11 + k));
            end
            tick();
        end
        io_ready_out[2] = 1'b0;
        checks++;
        if (io_valid_out[2] !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop_count valid=%b exp=0", io_valid_out[2]);
        end
    endtask

    task automatic test_reset_pending();
        clear_inputs();
        set_write(0, 10, 4, 8'hEE);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_raddr(10);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== 8'h00) begin
                failures++;
                $display("FAIL rst_pending core=%0d got=%h exp=00", c, rdata[c*DW +: DW]);
            end
        end
        checks++;
        if (io_valid_out !== 4'h0 || io_overflow !== 4'h0 || io_data_out !== '0) begin
            failures++;
            $display("FAIL rst_pending_io valid=%b ovf=%b data=%h exp 0", io_valid_out, io_overflow, io_data_out);
        end
        set_write(0, 10, 4, 8'hEE);
        tick();
        clear_inputs();
        tick();
        set_raddr(10);
        for (int c = 0; c < CORES; c++) begin
            checks++;
            if (rdata[c*DW +: DW] !== 8'hEE) begin
                failures++;
                $display("FAIL rst_then_write core=%0d got=%h exp=ee", c, rdata[c*DW +: DW]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        for (int n = 0; n < 150; n++) begin
            clear_inputs();
            for (int c = 0; c < CORES; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_write(c, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(28, 31),
                              $urandom_range(0, 7), $urandom_range(0, 255));
                end
            end
            for (int p = 0; p < IOP; p++) begin
                if ($urandom_range(0, 3) == 0) begin
                    io_valid_in[p] = 1'b1;
                    io_data_in[p*DW +: DW] = 8'($urandom_range(0, 255));
                end
                io_ready_out[p] = ($urandom_range(0, 2) == 0);
            end
            tick();
            for (int a = 0; a < DEPTH; a++) begin
                set_raddr(a);
                for (int c = 0; c < CORES; c++) begin
                    checks++;
                    if (rdata[c*DW +: DW] !== 8'(m_mem[c][a])) begin
                        failures++;
                        $display("FAIL rand_mem cyc=%0d core=%0d addr=%0d got=%h exp=%h", n, c, a, rdata[c*DW +: DW], 8'(m_mem[c][a]));
                    end
                end
            end
            for (int p = 0; p < IOP; p++) begin
                exp_d = (m_q[p].size() > 0) ? 8'(m_q[p][0]) : 8'h00;
                checks++;
                if (io_valid_out[p] !== (m_q[p].size() > 0) || io_data_out[p*DW +: DW] !== exp_d ||
                    io_overflow[p] !== m_ovf[p]) begin
                    failures++;
                    $display("FAIL rand_fifo cyc=%0d port=%0d valid=%b data=%h ovf=%b exp valid=%b data=%h ovf=%b",
                             n, p, io_valid_out[p], io_data_out[p*DW +: DW], io_overflow[p],
                             m_q[p].size() > 0, exp_d, m_ovf[p]);
                end
            end
        end
        io_ready_out = '0;
    endtask

    initial begin
        p_live = 1'b0;
        rst = 1'b1;
        clear_inputs();
        io_ready_out = '0;
        raddr = '0;
        test_reset();
        test_spread();
        test_conflict();
        test_broadcast_fifo();
        test_io_override();
        test_full_push_pop();
        test_reset_pending();
        rst = 1'b1; tick(); rst = 1'b0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
